// File: rtl/alu_arbiter_if.sv
// Bus bundle between the requesters, the alu_arbiter and the shared 16-bit ALU.
// slave modport is the arbiter's view; master modport is the requester/ALU side.
// Optional macro ALU_LOCK_EN adds the per-requester lock input.
interface alu_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req;
  logic [16*NREQ-1:0]   a_in;
  logic [16*NREQ-1:0]   b_in;
  logic [8*NREQ-1:0]    op_in;
  logic [NREQ-1:0]      cf_in;
`ifdef ALU_LOCK_EN
  logic [NREQ-1:0]      lock;
`endif
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic [15:0]          acc_out;
  logic [15:0]          c_out;
  logic                 c_flag_out;
  logic                 z_flag_out;
  logic                 o_flag_out;
  logic [15:0]          alu_a;
  logic [15:0]          alu_b;
  logic [7:0]           alu_op;
  logic                 alu_cf;
  logic [15:0]          alu_acc;
  logic [15:0]          alu_c;
  logic                 alu_c_flag;
  logic                 alu_z_flag;
  logic                 alu_o_flag;

  modport slave (
`ifdef ALU_LOCK_EN
    input  lock,
`endif
    input  req, a_in, b_in, op_in, cf_in,
    input  alu_acc, alu_c, alu_c_flag, alu_z_flag, alu_o_flag,
    output gnt, done, acc_out, c_out, c_flag_out, z_flag_out, o_flag_out,
    output alu_a, alu_b, alu_op, alu_cf
  );

  modport master (
`ifdef ALU_LOCK_EN
    output lock,
`endif
    output req, a_in, b_in, op_in, cf_in,
    output alu_acc, alu_c, alu_c_flag, alu_z_flag, alu_o_flag,
    input  gnt, done, acc_out, c_out, c_flag_out, z_flag_out, o_flag_out,
    input  alu_a, alu_b, alu_op, alu_cf
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one clocked 16-bit ALU between NREQ requesters.
// Flow: IDLE (pick winner, register operands) -> WAIT (ALU_LAT edges) ->
// RESP (one-cycle done pulse with captured acc/c/flags) -> IDLE.
// Optional macro ALU_LOCK_EN: a locked winner that still requests in RESP is
// granted again straight away, keeping multi-word ADC/SUC chains together.
module alu_arbiter #(
  parameter int NREQ    = 2,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(ALU_LAT + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   winner_q, winner_d;
  logic [IW-1:0]   last_winner_q, last_winner_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [15:0]     alu_a_q, alu_a_d;
  logic [15:0]     alu_b_q, alu_b_d;
  logic [7:0]      alu_op_q, alu_op_d;
  logic            alu_cf_q, alu_cf_d;
  logic [15:0]     acc_q, acc_d;
  logic [15:0]     c_q, c_d;
  logic            c_flag_q, c_flag_d;
  logic            z_flag_q, z_flag_d;
  logic            o_flag_q, o_flag_d;
`ifdef ALU_LOCK_EN
  logic            lock_hold_q, lock_hold_d;
`endif

  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;
  logic [15:0]     sel_a, sel_b;
  logic [7:0]      sel_op;
  logic            sel_cf;

  // Winner search: first active req upward from last_winner+1, unless a lock re-grant is pending
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_winner_q) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
`ifdef ALU_LOCK_EN
    if (lock_hold_q && bus.req[winner_q]) begin
      found = 1'b1;
      pick  = winner_q;
    end
`endif
  end

  // Operand mux selecting the candidate winner's packed slice
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    sel_cf = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) begin
        sel_a  = bus.a_in[16*i +: 16];
        sel_b  = bus.b_in[16*i +: 16];
        sel_op = bus.op_in[8*i +: 8];
        sel_cf = bus.cf_in[i];
      end
    end
  end

  // Next-state logic for the IDLE/WAIT/RESP sequence and all holding registers
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    winner_d      = winner_q;
    last_winner_d = last_winner_q;
    gnt_d         = gnt_q;
    done_d        = done_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    alu_cf_d      = alu_cf_q;
    acc_d         = acc_q;
    c_d           = c_q;
    c_flag_d      = c_flag_q;
    z_flag_d      = z_flag_q;
    o_flag_d      = o_flag_q;
`ifdef ALU_LOCK_EN
    lock_hold_d   = lock_hold_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          winner_d = pick;
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          alu_op_d = sel_op;
          alu_cf_d = sel_cf;
          gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          cnt_d    = CW'(ALU_LAT);
          state_d  = S_WAIT;
`ifdef ALU_LOCK_EN
          lock_hold_d = 1'b0;
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          acc_d    = bus.alu_acc;
          c_d      = bus.alu_c;
          c_flag_d = bus.alu_c_flag;
          z_flag_d = bus.alu_z_flag;
          o_flag_d = bus.alu_o_flag;
          done_d   = gnt_q;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        done_d  = '0;
        gnt_d   = '0;
        state_d = S_IDLE;
`ifdef ALU_LOCK_EN
        if (bus.lock[winner_q] && bus.req[winner_q]) begin
          lock_hold_d = 1'b1;
        end else begin
          last_winner_d = winner_q;
        end
`else
        last_winner_d = winner_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation and gives requester 0 top priority
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      winner_q      <= '0;
      last_winner_q <= IW'(NREQ - 1);
      gnt_q         <= '0;
      done_q        <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      alu_cf_q      <= 1'b0;
      acc_q         <= '0;
      c_q           <= '0;
      c_flag_q      <= 1'b0;
      z_flag_q      <= 1'b0;
      o_flag_q      <= 1'b0;
`ifdef ALU_LOCK_EN
      lock_hold_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      winner_q      <= winner_d;
      last_winner_q <= last_winner_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      alu_cf_q      <= alu_cf_d;
      acc_q         <= acc_d;
      c_q           <= c_d;
      c_flag_q      <= c_flag_d;
      z_flag_q      <= z_flag_d;
      o_flag_q      <= o_flag_d;
`ifdef ALU_LOCK_EN
      lock_hold_q   <= lock_hold_d;
`endif
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.acc_out    = acc_q;
  assign bus.c_out      = c_q;
  assign bus.c_flag_out = c_flag_q;
  assign bus.z_flag_out = z_flag_q;
  assign bus.o_flag_out = o_flag_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_cf     = alu_cf_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter (NREQ=3, ALU_LAT=1) with a one-stage ALU model.
// Inputs are driven and outputs sampled at the falling clock edge.
// Build with ALU_LOCK_EN defined to exercise the lock re-grant path.
module tb_alu_arbiter;
  localparam int NREQ    = 3;
  localparam int ALU_LAT = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_arbiter_if #(.NREQ(NREQ)) bus ();

  alu_arbiter #(.NREQ(NREQ), .ALU_LAT(ALU_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: one clock edge from operands to results (ADD, ADC, SUB, else pass a)
  always @(posedge clk) begin : alu_model
    logic [16:0] s;
    logic        ov;
    case (bus.alu_op)
      8'h01: begin
        s  = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        ov = (bus.alu_a[15] == bus.alu_b[15]) && (s[15] != bus.alu_a[15]);
      end
      8'h02: begin
        s  = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'h0, bus.alu_cf};
        ov = (bus.alu_a[15] == bus.alu_b[15]) && (s[15] != bus.alu_a[15]);
      end
      8'h03: begin
        s  = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        ov = (bus.alu_a[15] != bus.alu_b[15]) && (s[15] != bus.alu_a[15]);
      end
      default: begin
        s  = {1'b0, bus.alu_a};
        ov = 1'b0;
      end
    endcase
    bus.alu_acc    <= s[15:0];
    bus.alu_c      <= 16'h0;
    bus.alu_c_flag <= s[16];
    bus.alu_z_flag <= (s[15:0] == 16'h0);
    bus.alu_o_flag <= ov;
  end

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] op, input logic cf);
    bus.a_in[16*i +: 16] = a;
    bus.b_in[16*i +: 16] = b;
    bus.op_in[8*i +: 8]  = op;
    bus.cf_in[i]         = cf;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    bus.req = '0;
`ifdef ALU_LOCK_EN
    bus.lock = '0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.gnt !== 3'b000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 000", bus.gnt); end
    checks++;
    if (bus.done !== 3'b000) begin errors++; $display("[TB] FAIL reset_done: got %b expected 000", bus.done); end
    checks++;
    if (bus.acc_out !== 16'h0) begin errors++; $display("[TB] FAIL reset_acc: got %h expected 0000", bus.acc_out); end
    checks++;
    if (bus.alu_a !== 16'h0 || bus.alu_op !== 8'h0) begin
      errors++; $display("[TB] FAIL reset_alu_regs: got a=%h op=%h expected 0/0", bus.alu_a, bus.alu_op);
    end
    reset = 1'b1;
  endtask

  task automatic test_single_add();
    set_op(0, 16'd5, 16'd7, 8'h01, 1'b0);
    bus.req = 3'b001;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 3'b001) begin errors++; $display("[TB] FAIL add_gnt: got %b expected 001", bus.gnt); end
    checks++;
    if (bus.alu_a !== 16'd5 || bus.alu_b !== 16'd7 || bus.alu_op !== 8'h01) begin
      errors++; $display("[TB] FAIL add_operands: got a=%h b=%h op=%h expected 0005/0007/01", bus.alu_a, bus.alu_b, bus.alu_op);
    end
    set_op(0, 16'hdead, 16'hbeef, 8'h03, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.done !== 3'b000) begin errors++; $display("[TB] FAIL add_early_done: got %b expected 000", bus.done); end
    @(negedge clk);
    checks++;
    if (bus.done !== 3'b001 || bus.gnt !== 3'b001) begin
      errors++; $display("[TB] FAIL add_done: got done=%b gnt=%b expected 001/001", bus.done, bus.gnt);
    end
    checks++;
    if (bus.acc_out !== 16'd12 || bus.z_flag_out !== 1'b0) begin
      errors++; $display("[TB] FAIL add_result: got acc=%h z=%b expected 000c/0", bus.acc_out, bus.z_flag_out);
    end
    bus.req = 3'b000;
    @(negedge clk);
    checks++;
    if (bus.done !== 3'b000 || bus.gnt !== 3'b000 || bus.acc_out !== 16'd12) begin
      errors++; $display("[TB] FAIL add_after: got done=%b gnt=%b acc=%h expected 000/000/000c", bus.done, bus.gnt, bus.acc_out);
    end
  endtask

  task automatic test_zero_flag();
    logic gnt0_seen = 1'b0;
    set_op(1, 16'd9, 16'd9, 8'h03, 1'b0);
    bus.req = 3'b010;
    @(negedge clk);
    gnt0_seen |= bus.gnt[0];
    checks++;
    if (bus.gnt !== 3'b010) begin errors++; $display("[TB] FAIL zero_gnt: got %b expected 010", bus.gnt); end
    @(negedge clk);
    gnt0_seen |= bus.gnt[0];
    @(negedge clk);
    gnt0_seen |= bus.gnt[0];
    checks++;
    if (bus.done !== 3'b010) begin errors++; $display("[TB] FAIL zero_done: got %b expected 010", bus.done); end
    checks++;
    if (bus.acc_out !== 16'h0 || bus.z_flag_out !== 1'b1) begin
      errors++; $display("[TB] FAIL zero_result: got acc=%h z=%b expected 0000/1", bus.acc_out, bus.z_flag_out);
    end
    bus.req = 3'b000;
    @(negedge clk);
    gnt0_seen |= bus.gnt[0];
    checks++;
    if (gnt0_seen !== 1'b0) begin errors++; $display("[TB] FAIL zero_gnt0: got %b expected 0", gnt0_seen); end
  endtask

  task automatic test_contention();
    int order[4];
    int stamp[4];
    logic [15:0] accs[4];
    int exp_order[4] = '{0, 1, 0, 1};
    logic [15:0] exp_acc[4] = '{16'd3, 16'd30, 16'd3, 16'd30};
    int n = 0;
    int cyc = 0;
    do_reset();
    set_op(0, 16'd1, 16'd2, 8'h01, 1'b0);
    set_op(1, 16'd10, 16'd20, 8'h01, 1'b0);
    bus.req = 3'b011;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.done != 3'b000) begin
        order[n] = onehot_idx(bus.done);
        stamp[n] = cyc;
        accs[n]  = bus.acc_out;
        if (order[n] >= 0) bus.req[order[n]] = 1'b0;
        n++;
        if (n == 2) bus.req = 3'b011;
      end
    end
    bus.req = 3'b000;
    checks++;
    if (n != 4) begin
      errors++; $display("[TB] FAIL contention_timeout: got %0d done pulses expected 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] != exp_order[i] || accs[i] !== exp_acc[i]) begin
          errors++; $display("[TB] FAIL contention_op%0d: got idx=%0d acc=%h expected idx=%0d acc=%h", i, order[i], accs[i], exp_order[i], exp_acc[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (stamp[i] - stamp[i-1] != ALU_LAT + 3) begin
          errors++; $display("[TB] FAIL contention_gap%0d: got %0d expected %0d", i, stamp[i] - stamp[i-1], ALU_LAT + 3);
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fairness();
    int grants[6];
    int exp_g[6] = '{0, 1, 2, 0, 1, 2};
    int ng = 0;
    int cyc = 0;
    logic [NREQ-1:0] prev = '0;
    do_reset();
    set_op(0, 16'd1, 16'd1, 8'h01, 1'b0);
    set_op(1, 16'd2, 16'd2, 8'h01, 1'b0);
    set_op(2, 16'd3, 16'd3, 8'h01, 1'b0);
    bus.req = 3'b111;
    while (ng < 6 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt != 3'b000 && prev == 3'b000) begin
        grants[ng] = onehot_idx(bus.gnt);
        ng++;
      end
      prev    = bus.gnt;
      bus.req = 3'b111 & ~bus.done;
    end
    bus.req = 3'b000;
    checks++;
    if (ng != 6) begin
      errors++; $display("[TB] FAIL fair_timeout: got %0d grants expected 6", ng);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (grants[i] != exp_g[i]) begin
          errors++; $display("[TB] FAIL fair_grant%0d: got %0d expected %0d", i, grants[i], exp_g[i]);
        end
      end
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (grants[i] == grants[i-1]) begin
          errors++; $display("[TB] FAIL fair_repeat%0d: got %0d twice expected a different index", i, grants[i]);
        end
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    logic spurious = 1'b0;
    logic got = 1'b0;
    do_reset();
    set_op(0, 16'd3, 16'd4, 8'h01, 1'b0);
    bus.req = 3'b001;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 3'b001) begin errors++; $display("[TB] FAIL midrst_gnt: got %b expected 001", bus.gnt); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 3'b000 || bus.done !== 3'b000 || bus.acc_out !== 16'h0 || bus.alu_a !== 16'h0) begin
      errors++; $display("[TB] FAIL midrst_clear: got gnt=%b done=%b acc=%h a=%h expected all zero", bus.gnt, bus.done, bus.acc_out, bus.alu_a);
    end
    reset   = 1'b1;
    bus.req = 3'b000;
    repeat (8) begin
      @(negedge clk);
      if (bus.done != 3'b000) spurious = 1'b1;
    end
    checks++;
    if (spurious !== 1'b0) begin errors++; $display("[TB] FAIL midrst_spurious_done: got %b expected 0", spurious); end
    bus.req = 3'b001;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.done != 3'b000) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++; $display("[TB] FAIL midrst_timeout: got no done expected done 001");
    end else if (bus.done !== 3'b001 || bus.acc_out !== 16'd7) begin
      errors++; $display("[TB] FAIL midrst_serve: got done=%b acc=%h expected 001/0007", bus.done, bus.acc_out);
    end
    bus.req = 3'b000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lock_chain();
    int grants[3];
`ifdef ALU_LOCK_EN
    int exp_g[3] = '{0, 0, 1};
`else
    int exp_g[3] = '{0, 1, 0};
`endif
    int ng = 0;
    int nd = 0;
    int cyc = 0;
    logic d0 = 1'b0;
    logic [NREQ-1:0] prev = '0;
    int idx;
    do_reset();
    set_op(0, 16'hffff, 16'h0001, 8'h01, 1'b0);
    set_op(1, 16'h0100, 16'h0001, 8'h01, 1'b0);
`ifdef ALU_LOCK_EN
    bus.lock = 3'b001;
`endif
    bus.req = 3'b011;
    while ((ng < 3 || nd < 3) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt != 3'b000 && prev == 3'b000 && ng < 3) begin
        grants[ng] = onehot_idx(bus.gnt);
        ng++;
      end
      prev = bus.gnt;
      if (bus.done != 3'b000) begin
        idx = onehot_idx(bus.done);
        nd++;
        if (idx == 0 && !d0) begin
          d0 = 1'b1;
          checks++;
          if (bus.acc_out !== 16'h0 || bus.c_flag_out !== 1'b1) begin
            errors++; $display("[TB] FAIL chain_low: got acc=%h c=%b expected 0000/1", bus.acc_out, bus.c_flag_out);
          end
          set_op(0, 16'h0000, 16'h0000, 8'h02, 1'b1);
        end else if (idx == 0) begin
          checks++;
          if (bus.acc_out !== 16'h0001) begin
            errors++; $display("[TB] FAIL chain_high: got acc=%h expected 0001", bus.acc_out);
          end
          bus.req[0] = 1'b0;
`ifdef ALU_LOCK_EN
          bus.lock = 3'b000;
`endif
        end else begin
          checks++;
          if (bus.acc_out !== 16'h0101) begin
            errors++; $display("[TB] FAIL chain_other: got acc=%h expected 0101", bus.acc_out);
          end
          bus.req[1] = 1'b0;
        end
      end
    end
    bus.req = 3'b000;
    checks++;
    if (ng != 3 || nd != 3) begin
      errors++; $display("[TB] FAIL chain_timeout: got %0d grants %0d dones expected 3/3", ng, nd);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (grants[i] != exp_g[i]) begin
          errors++; $display("[TB] FAIL chain_grant%0d: got %0d expected %0d", i, grants[i], exp_g[i]);
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // Watchdog so a stuck handshake can never hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    bus.req   = '0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.op_in = '0;
    bus.cf_in = '0;
`ifdef ALU_LOCK_EN
    bus.lock  = '0;
`endif
    test_reset();
    test_single_add();
    test_zero_flag();
    test_contention();
    test_fairness();
    test_reset_mid_wait();
    test_lock_chain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
